// File: rtl/glasfaser_pkg.sv
// Shared types and constants for the glasfaser audio path.
package glasfaser_pkg;

    localparam int FLASH_ADDR_W = 24;

    typedef logic [31:0] sample_t;

    localparam logic [FLASH_ADDR_W-1:0] DEFAULT_BASE_ADDR = 24'h000000;
    localparam logic [FLASH_ADDR_W-1:0] DEFAULT_SIZE      = 24'h0EA600;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_e;

    // Next word address inside the circular region. The sum is formed one bit
    // wider than the address so a region ending at the top of flash cannot
    // overflow before the wrap comparison.
    function automatic logic [FLASH_ADDR_W-1:0] next_addr(
        input logic [FLASH_ADDR_W-1:0] addr,
        input logic [FLASH_ADDR_W-1:0] base,
        input logic [FLASH_ADDR_W-1:0] size
    );
        logic [FLASH_ADDR_W:0] sum_s;
        logic [FLASH_ADDR_W:0] end_s;
        sum_s = {1'b0, addr} + (FLASH_ADDR_W+1)'(4);
        end_s = {1'b0, base} + {1'b0, size};
        if (sum_s == end_s) begin
            next_addr = base;
        end else begin
            next_addr = sum_s[FLASH_ADDR_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO. Pointers carry one extra wrap bit so a
// full buffer and an empty buffer are told apart without a separate flag.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    level_q, level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    // Next-state for storage, pointers and occupancy; overflow/underflow are blocked here.
    always_comb begin
        do_push_s = push & ~full_o;
        do_pop_s  = pop & ~empty_o;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   level_d = level_q + PW'(1);
            2'b01:   level_d = level_q - PW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/audio_prefetch.sv
// Flash-to-S/PDIF prefetch buffer: walks a circular PCM region one stereo word
// at a time, keeps a small FIFO topped up and answers each sample request
// with the next word, or with silence (counted) when starved.
module audio_prefetch
    import glasfaser_pkg::*;
#(
    parameter logic [FLASH_ADDR_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter logic [FLASH_ADDR_W-1:0] SIZE      = DEFAULT_SIZE,
    parameter int                      DEPTH     = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      enable,
    output logic                      flash_valid,
    output logic [FLASH_ADDR_W-1:0]   flash_addr,
    input  logic                      flash_ready,
    input  logic [31:0]               flash_rdata,
    input  logic                      sample_req,
    output logic [31:0]               sample_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic [7:0]                underrun_cnt_o
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    req_state_e              state_q, state_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    sample_t                 sample_q, sample_d;
    logic [7:0]              underrun_q, underrun_d;

    logic                    push_s;
    logic                    pop_s;
    sample_t                 head_s;
    logic                    full_s;
    logic                    empty_s;
    logic [LW-1:0]           level_s;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_s),
        .push_data (flash_rdata),
        .pop       (pop_s),
        .head_o    (head_s),
        .full_o    (full_s),
        .empty_o   (empty_s),
        .level_o   (level_s)
    );

    // Request FSM and address generator: one outstanding read, never abandoned.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable && (level_s < DEPTH_L)) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (flash_ready) begin
                    push_s  = ~full_s;
                    addr_d  = next_addr(addr_q, BASE_ADDR, SIZE);
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sample service: hand out the head word, or silence plus a saturating underrun count.
    always_comb begin
        sample_d   = sample_q;
        underrun_d = underrun_q;
        pop_s      = 1'b0;
        if (sample_req) begin
            if (!empty_s) begin
                sample_d = head_s;
                pop_s    = 1'b1;
            end else begin
                sample_d = 32'h0000_0000;
                if (underrun_q == 8'hFF) begin
                    underrun_d = 8'hFF;
                end else begin
                    underrun_d = underrun_q + 8'h01;
                end
            end
        end else begin
            sample_d = sample_q;
        end
    end

    // Control, address, sample and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            addr_q     <= BASE_ADDR;
            sample_q   <= 32'h0000_0000;
            underrun_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            sample_q   <= sample_d;
            underrun_q <= underrun_d;
        end
    end

    assign flash_valid    = (state_q == ST_REQ);
    assign flash_addr     = addr_q;
    assign sample_o       = sample_q;
    assign level_o        = level_s;
    assign underrun_cnt_o = underrun_q;

endmodule
